dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: maximum consecutive contested pipeline grants before the debug/loader port wins.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 p_req, p_wr  input  1 each  pipeline MEM-stage access request and write enable; held until p_done.
REQ-005 p_addr, p_wdata  input  32 each  pipeline address and store data.
REQ-006 p_dsize  input  2  pipeline access size: 0=byte, 1=half, 2=invalid, 3=word.
REQ-007 d_req, d_wr, d_addr[31:0], d_wdata[31:0], d_dsize[1:0]  input  debug/loader port; same meanings as the p_* inputs.
REQ-008 p_stall  output  1  p_req AND NOT p_done (combinational); freezes the pipeline.
REQ-009 p_done, d_done  output  1 each  one-cycle completion pulse per port.
REQ-010 p_rdata, d_rdata  output  32 each  registered read data per port.
REQ-011 m_addr, m_wdata  output  32 each  shared data-memory address and write data.
REQ-012 m_wr  output  1  shared data-memory write strobe.
REQ-013 m_dsize  output  2  shared data-memory access size.
REQ-014 m_rdata  input  32  shared data-memory combinational read data.

Function
REQ-015 FSM states: IDLE, ACCESS, DONE; IDLE->ACCESS when either request is sampled, ACCESS->DONE unconditionally, DONE->IDLE unconditionally.
REQ-016 In IDLE, a sole requester is granted; when both request, P is granted unless starve_cnt==STARVE_MAX, in which case D is granted.
REQ-017 On grant, owner, wr, addr, wdata and dsize are latched into internal registers; later changes on the requester inputs do not affect the access in flight.
REQ-018 In ACCESS, m_addr, m_wdata and m_dsize come from the latched registers.
REQ-019 In ACCESS, m_wr equals latched wr AND (latched dsize != 2).
REQ-020 Outside ACCESS, m_wr is 0 and m_addr, m_wdata and m_dsize are 0.
REQ-021 At the end of a read ACCESS cycle, m_rdata is captured into the owner's rdata register; if dsize==2, 0 is captured instead.
REQ-022 The other port's rdata, and the owner's rdata on a write, hold their previous values.
REQ-023 In DONE, only the owner's done output is 1; latency is exactly 2 cycles from the request-sampling edge to done, and throughput is 1 access per 3 cycles.
REQ-024 Requests are not sampled in ACCESS or DONE; a requester keeping req high after done gets a new access starting at the next IDLE.
REQ-025 starve_cnt (width clog2(STARVE_MAX+1)) increments on a P grant while d_req=1, saturating at STARVE_MAX; it clears on any D grant and holds on an uncontested P grant.
REQ-026 Dsize value 2 still completes normally, with done pulsed, no write issued and rdata=0.

Reset
REQ-027 While rst_n=0: state=IDLE, starve_cnt=0, all latched registers 0, p_done=d_done=0, p_rdata=d_rdata=0, m_wr=0, m_addr=m_wdata=0, m_dsize=0.
REQ-028 Reset asserted during ACCESS aborts the access immediately: m_wr drops asynchronously and no done is issued.
REQ-029 After rst_n rises, the first request is sampled at the first rising clk edge.

Verification
REQ-030 P word read, addr 0x100, m_rdata=0xDEADBEEF: m_addr=0x100 in cycle 1, then p_done=1 and p_rdata=0xDEADBEEF in cycle 2; p_stall=1 in cycles 0-1 and 0 in cycle 2.
REQ-031 D byte write, addr 0x20, wdata 0xAB: exactly one m_wr pulse with m_dsize=0 and m_wdata=0xAB, then d_done=1; d_rdata is unchanged.
REQ-032 p_req and d_req both held high continuously with STARVE_MAX=4: grant order is P,P,P,P,D,P,P,P,P,D.
REQ-033 P write with p_dsize=2: m_wr stays 0 throughout, p_done pulses in cycle 2, and p_rdata is unchanged.
REQ-034 rst_n pulled low mid-ACCESS of a D write: m_wr=0 immediately, no d_done, all outputs at reset values; the next request after release completes with 2-cycle latency.
REQ-035 During P ownership, p_addr is changed in the ACCESS cycle: m_addr keeps the latched address.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbitrates one shared data-memory port between the pipeline MEM stage (P) and a
// debug/loader port (D). Every access runs IDLE -> ACCESS -> DONE, and D cannot be starved forever.
module dmem_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        p_req,
   input  logic        p_wr,
   input  logic [31:0] p_addr,
   input  logic [31:0] p_wdata,
   input  logic [1:0]  p_dsize,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [1:0]  d_dsize,
   output logic        p_stall,
   output logic        p_done,
   output logic        d_done,
   output logic [31:0] p_rdata,
   output logic [31:0] d_rdata,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic        m_wr,
   output logic [1:0]  m_dsize,
   input  logic [31:0] m_rdata
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
   localparam logic [1:0] DSIZE_BAD = 2'd2;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic {OWN_P, OWN_D} owner_t;

   state_t        state, state_nxt;
   owner_t        owner;
   logic          lat_wr;
   logic [31:0]   lat_addr, lat_wdata;
   logic [1:0]    lat_dsize;
   logic [CW-1:0] starve_cnt;
   logic          start, grant_d;
   logic [31:0]   rdata_cap;

   // Under contention P wins until it has taken STARVE_MAX grants in a row.
   assign start     = (state == IDLE) && (p_req || d_req);
   assign grant_d   = d_req && (!p_req || (starve_cnt == STARVE_LIM));
   assign rdata_cap = (lat_dsize == DSIZE_BAD) ? 32'd0 : m_rdata;
   assign p_stall   = p_req && !p_done;

   // NOTE: sequential state uses non-blocking assignments so every register sees the pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      m_addr    = '0;
      m_wdata   = '0;
      m_dsize   = '0;
      m_wr      = 1'b0;
      p_done    = 1'b0;
      d_done    = 1'b0;
      case (state)
         IDLE: if (p_req || d_req) state_nxt = ACCESS;
         ACCESS: begin
            state_nxt = DONE;
            m_addr    = lat_addr;
            m_wdata   = lat_wdata;
            m_dsize   = lat_dsize;
            m_wr      = lat_wr && (lat_dsize != DSIZE_BAD);
         end
         DONE: begin
            state_nxt = IDLE;
            p_done    = (owner == OWN_P);
            d_done    = (owner == OWN_D);
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: these are plain registers, not a memory array, so all of them take the async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner      <= OWN_P;
         lat_wr     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_dsize  <= '0;
         starve_cnt <= '0;
      end else if (start) begin
         owner     <= grant_d ? OWN_D : OWN_P;
         lat_wr    <= grant_d ? d_wr : p_wr;
         lat_addr  <= grant_d ? d_addr : p_addr;
         lat_wdata <= grant_d ? d_wdata : p_wdata;
         lat_dsize <= grant_d ? d_dsize : p_dsize;
         if (grant_d)
            starve_cnt <= '0;
         else if (d_req && (starve_cnt != STARVE_LIM))
            starve_cnt <= starve_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_rdata <= '0;
         d_rdata <= '0;
      end else if ((state == ACCESS) && !lat_wr) begin
         if (owner == OWN_P) p_rdata <= rdata_cap;
         else                d_rdata <= rdata_cap;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, reads, writes, invalid size, latching,
// starvation order and reset during an access, with hand-computed expectations.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        p_req = 1'b0, p_wr = 1'b0, d_req = 1'b0, d_wr = 1'b0;
   logic [31:0] p_addr = '0, p_wdata = '0, d_addr = '0, d_wdata = '0;
   logic [1:0]  p_dsize = '0, d_dsize = '0;
   logic        p_stall, p_done, d_done, m_wr;
   logic [31:0] p_rdata, d_rdata, m_addr, m_wdata;
   logic [1:0]  m_dsize;
   logic [31:0] m_rdata = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.STARVE_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .p_req(p_req), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata), .p_dsize(p_dsize),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_dsize(d_dsize),
      .p_stall(p_stall), .p_done(p_done), .d_done(d_done),
      .p_rdata(p_rdata), .d_rdata(d_rdata),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_wr(m_wr), .m_dsize(m_dsize),
      .m_rdata(m_rdata)
   );

   // Each cycle: land 2 time units after the rising edge, check, then drive.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      p_req = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      n_checks++;
      if ({p_done, d_done, m_wr} !== 3'b000) begin
         n_fail++; $display("FAIL reset_strobes: got %b expected 000", {p_done, d_done, m_wr});
      end
      n_checks++;
      if ({m_addr, m_wdata, m_dsize} !== 66'd0) begin
         n_fail++; $display("FAIL reset_mem_bus: got %h expected 0", {m_addr, m_wdata, m_dsize});
      end
      n_checks++;
      if ({p_rdata, d_rdata} !== 64'd0) begin
         n_fail++; $display("FAIL reset_rdata: got %h expected 0", {p_rdata, d_rdata});
      end
      n_checks++;
      if (p_stall !== 1'b1) begin
         n_fail++; $display("FAIL reset_stall: got %b expected 1", p_stall);
      end
      p_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_p_read();
      step();
      p_req = 1'b1; p_wr = 1'b0; p_addr = 32'h100; p_dsize = 2'd3; m_rdata = 32'hDEADBEEF;
      #1;
      n_checks++;
      if ({p_stall, m_addr} !== {1'b1, 32'h0}) begin
         n_fail++; $display("FAIL p_read_c0: stall/addr got %b/%h expected 1/0", p_stall, m_addr);
      end
      step();
      n_checks++;
      if ({m_addr, m_dsize, m_wr, p_stall, p_done} !== {32'h100, 2'd3, 1'b0, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL p_read_c1: addr %h size %0d wr %b stall %b done %b expected 100/3/0/1/0",
                            m_addr, m_dsize, m_wr, p_stall, p_done);
      end
      step();
      n_checks++;
      if ({p_done, d_done, p_stall} !== 3'b100) begin
         n_fail++; $display("FAIL p_read_c2: done/d_done/stall got %b expected 100", {p_done, d_done, p_stall});
      end
      n_checks++;
      if (p_rdata !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL p_read_data: got %h expected deadbeef", p_rdata);
      end
      p_req = 1'b0; m_rdata = 32'h0BAD0BAD;
      step();
      n_checks++;
      if ({p_done, p_rdata} !== {1'b0, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL p_read_hold: done/rdata got %b/%h expected 0/deadbeef", p_done, p_rdata);
      end
   endtask

   task automatic test_d_read();
      step();
      d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h24; d_dsize = 2'd3; m_rdata = 32'h12345678;
      step();
      n_checks++;
      if (m_addr !== 32'h24) begin
         n_fail++; $display("FAIL d_read_addr: got %h expected 24", m_addr);
      end
      step();
      n_checks++;
      if ({d_done, p_done, d_rdata, p_rdata} !== {2'b10, 32'h12345678, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL d_read_c2: done %b%b d_rdata %h p_rdata %h expected 10/12345678/deadbeef",
                            d_done, p_done, d_rdata, p_rdata);
      end
      d_req = 1'b0;
   endtask

   task automatic test_d_write();
      int wr_pulses;
      wr_pulses = 0;
      step();
      d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h20; d_wdata = 32'hAB; d_dsize = 2'd0;
      m_rdata = 32'hFFFFFFFF;
      #1;
      if (m_wr) wr_pulses++;
      step();
      if (m_wr) wr_pulses++;
      n_checks++;
      if ({m_wr, m_dsize, m_wdata, m_addr} !== {1'b1, 2'd0, 32'hAB, 32'h20}) begin
         n_fail++; $display("FAIL d_write_c1: wr %b size %0d wdata %h addr %h expected 1/0/ab/20",
                            m_wr, m_dsize, m_wdata, m_addr);
      end
      step();
      if (m_wr) wr_pulses++;
      n_checks++;
      if ({d_done, p_done, d_rdata} !== {2'b10, 32'h12345678}) begin
         n_fail++; $display("FAIL d_write_c2: done %b%b d_rdata %h expected 10/12345678",
                            d_done, p_done, d_rdata);
      end
      d_req = 1'b0; d_wr = 1'b0;
      step();
      if (m_wr) wr_pulses++;
      n_checks++;
      if (wr_pulses !== 1) begin
         n_fail++; $display("FAIL d_write_pulses: got %0d expected 1", wr_pulses);
      end
   endtask

   task automatic test_invalid_size();
      step();
      p_req = 1'b1; p_wr = 1'b1; p_addr = 32'h80; p_wdata = 32'h77; p_dsize = 2'd2;
      step();
      n_checks++;
      if ({m_wr, m_dsize} !== {1'b0, 2'd2}) begin
         n_fail++; $display("FAIL bad_write_c1: wr/size got %b/%0d expected 0/2", m_wr, m_dsize);
      end
      step();
      n_checks++;
      if ({p_done, m_wr, p_rdata} !== {2'b10, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL bad_write_c2: done %b wr %b rdata %h expected 1/0/deadbeef",
                            p_done, m_wr, p_rdata);
      end
      p_wr = 1'b0; m_rdata = 32'h99999999;
      step();
      step();
      step();
      n_checks++;
      if ({p_done, p_rdata} !== {1'b1, 32'h0}) begin
         n_fail++; $display("FAIL bad_read: done/rdata got %b/%h expected 1/0", p_done, p_rdata);
      end
      p_req = 1'b0;
   endtask

   task automatic test_addr_hold();
      step();
      p_req = 1'b1; p_wr = 1'b1; p_addr = 32'h200; p_wdata = 32'h11223344; p_dsize = 2'd1;
      step();
      p_addr = 32'h300; p_wdata = 32'h0; p_dsize = 2'd3;
      #1;
      n_checks++;
      if ({m_addr, m_wdata, m_dsize, m_wr} !== {32'h200, 32'h11223344, 2'd1, 1'b1}) begin
         n_fail++; $display("FAIL addr_hold: addr %h wdata %h size %0d wr %b expected 200/11223344/1/1",
                            m_addr, m_wdata, m_dsize, m_wr);
      end
      step();
      n_checks++;
      if (p_done !== 1'b1) begin
         n_fail++; $display("FAIL addr_hold_done: got %b expected 1", p_done);
      end
      p_req = 1'b0; p_wr = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [0:9] exp_d;
      int cyc, last;
      bit found;
      exp_d = 10'b0000100001;
      cyc = 0; last = 0;
      step();
      p_req = 1'b1; d_req = 1'b1; p_wr = 1'b0; d_wr = 1'b0;
      p_dsize = 2'd3; d_dsize = 2'd3; p_addr = 32'h400; d_addr = 32'h500;
      m_rdata = 32'h3C3C3C3C;
      for (int i = 0; i < 10; i++) begin
         found = 1'b0;
         for (int w = 0; w < 6 && !found; w++) begin
            step();
            cyc++;
            if (p_done || d_done) found = 1'b1;
         end
         n_checks++;
         if (!found) begin
            n_fail++; $display("FAIL b2b_timeout: grant %0d got none expected done", i);
         end else begin
            n_checks++;
            if ({d_done, p_done} !== {exp_d[i], !exp_d[i]}) begin
               n_fail++; $display("FAIL b2b_order: grant %0d got d%b p%b expected d%b", i, d_done, p_done, exp_d[i]);
            end
            if (i > 0) begin
               n_checks++;
               if (cyc - last !== 3) begin
                  n_fail++; $display("FAIL b2b_spacing: grant %0d got %0d cycles expected 3", i, cyc - last);
               end
            end
         end
         last = cyc;
      end
      p_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      step();
      d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h40; d_wdata = 32'h5A; d_dsize = 2'd3;
      step();
      n_checks++;
      if (m_wr !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_pre: wr got %b expected 1", m_wr);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({m_wr, m_addr, m_wdata, m_dsize, d_done} !== 68'd0) begin
         n_fail++; $display("FAIL rst_mid_bus: wr %b addr %h wdata %h size %0d done %b expected all 0",
                            m_wr, m_addr, m_wdata, m_dsize, d_done);
      end
      n_checks++;
      if ({p_rdata, d_rdata} !== 64'd0) begin
         n_fail++; $display("FAIL rst_mid_rdata: got %h expected 0", {p_rdata, d_rdata});
      end
      d_wr = 1'b0; d_addr = 32'h44; m_rdata = 32'hCAFEF00D;
      for (int k = 0; k < 2; k++) begin
         step();
         n_checks++;
         if ({d_done, m_wr} !== 2'b00) begin
            n_fail++; $display("FAIL rst_mid_hold: cycle %0d done/wr got %b expected 00", k, {d_done, m_wr});
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      n_checks++;
      if (m_addr !== 32'h44) begin
         n_fail++; $display("FAIL rst_mid_after_c1: addr got %h expected 44", m_addr);
      end
      step();
      n_checks++;
      if ({d_done, d_rdata} !== {1'b1, 32'hCAFEF00D}) begin
         n_fail++; $display("FAIL rst_mid_after_c2: done/rdata got %b/%h expected 1/cafef00d", d_done, d_rdata);
      end
      d_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_p_read();
      test_d_read();
      test_d_write();
      test_invalid_size();
      test_addr_hold();
      test_back_to_back();
      test_reset_mid_access();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
